// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root request scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StOut
  } sched_state_e;

  // Extra edges of RUN tolerated beyond the engine's nominal N/2 latency.
  localparam int unsigned TimeoutSlack = 3;

  function automatic int unsigned tag_width(input int unsigned nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/sqrt_scheduler_if.sv
// Request, engine and result signals of the square-root scheduler.
interface sqrt_scheduler_if
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N    = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = tag_width(NREQ)
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              sq_rst;
  logic [N-1:0]      sq_num;
  logic              sq_done;
  logic [N/2-1:0]    sq_root;
  logic              out_valid;
  logic              out_ready;
  logic [N/2-1:0]    out_root;
  logic [TAGW-1:0]   out_tag;
  logic              busy;
  logic              err;

  modport master (
    input  req_valid, req_data, sq_done, sq_root, out_ready,
    output req_ready, sq_rst, sq_num, out_valid, out_root, out_tag, busy, err
  );

  modport slave (
    output req_valid, req_data, sq_done, sq_root, out_ready,
    input  req_ready, sq_rst, sq_num, out_valid, out_root, out_tag, busy, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TAGW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [TAGW-1:0] idx_o,
  output logic            any_o
);

  logic [TAGW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = TAGW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_root.sv
// Iterative square-root engine: one root bit per edge, MSB first, done N/2 edges after rst_i falls.
module square_root #(
  parameter int unsigned N = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   num_i,
  output logic           done_o,
  output logic [N/2-1:0] root_o
);

  localparam int unsigned RW = N / 2;
  localparam int unsigned BW = (RW > 1) ? $clog2(RW) : 1;

  logic [RW-1:0] root_q, trial;
  logic [N-1:0]  trial_sq;
  logic [BW-1:0] bit_q;
  logic          done_q;

  always_comb begin
    trial        = root_q;
    trial[bit_q] = 1'b1;
    trial_sq     = N'(trial) * N'(trial);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      root_q <= '0;
      bit_q  <= BW'(RW - 1);
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (trial_sq <= num_i) root_q <= trial;
      if (bit_q == '0) done_q <= 1'b1;
      else             bit_q  <= bit_q - BW'(1);
    end
  end

  assign done_o = done_q;
  assign root_o = root_q;

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin sharing of one iterative square-root engine among NREQ requesters.
// Build option: SQRT_SCHED_TIMEOUT_EN adds a RUN watchdog that raises sticky err.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N    = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = tag_width(NREQ)
) (
  input logic              Clock,
  input logic              reset,
  sqrt_scheduler_if.master bus
);

  localparam int unsigned RW = N / 2;

  sched_state_e    state_q;
  logic [TAGW-1:0] ptr_q, tag_q, gnt_idx, next_ptr;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            sq_rst_q, out_valid_q;
  logic [N-1:0]    sq_num_q, grant_data;
  logic [RW-1:0]   root_q;

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int unsigned TmoLimit = RW + TimeoutSlack;
  localparam int unsigned CntW     = $clog2(TmoLimit);
  logic [CntW-1:0] tmo_q;
  logic            err_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign next_ptr   = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
  assign grant_data = bus.req_data[32'(gnt_idx) * N +: N];

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      tag_q       <= '0;
      sq_rst_q    <= 1'b1;
      sq_num_q    <= '0;
      out_valid_q <= 1'b0;
      root_q      <= '0;
`ifdef SQRT_SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            sq_num_q <= grant_data;
            tag_q    <= gnt_idx;
            ptr_q    <= next_ptr;
            sq_rst_q <= 1'b0;
            state_q  <= StRun;
`ifdef SQRT_SCHED_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        StRun: begin
          if (bus.sq_done) begin
            root_q      <= bus.sq_root;
            out_valid_q <= 1'b1;
            sq_rst_q    <= 1'b1;
            state_q     <= StOut;
          end
`ifdef SQRT_SCHED_TIMEOUT_EN
          else if (tmo_q == CntW'(TmoLimit - 1)) begin
            // Engine never answered: hand back a zero root so the requester is not starved.
            root_q      <= '0;
            out_valid_q <= 1'b1;
            sq_rst_q    <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= StOut;
          end else begin
            tmo_q <= tmo_q + CntW'(1);
          end
`endif
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grant is gated by reset so req_ready reads 0 while the block is held in reset.
  assign bus.req_ready = (state_q == StIdle && reset) ? gnt : '0;
  assign bus.sq_rst    = sq_rst_q;
  assign bus.sq_num    = sq_num_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_root  = root_q;
  assign bus.out_tag   = tag_q;
  assign bus.busy      = (state_q != StIdle);
`ifdef SQRT_SCHED_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Randomised self-checking bench for sqrt_scheduler driving the real square_root engine.
module tb_sqrt_scheduler;

  localparam int unsigned N      = 10;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned TAGW   = 2;
  localparam int unsigned RW     = N / 2;
  localparam int unsigned LAT    = RW + 1;
  localparam int unsigned PERIOD = RW + 3;

  logic          Clock = 1'b0;
  logic          reset = 1'b0;
  logic          force_low = 1'b0;
  logic          eng_done;
  logic [RW-1:0] eng_root;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_ptr = 0;
  int exp_tag_q[$];
  int exp_root_q[$];
  int acc_cyc_q[$];

  sqrt_scheduler_if #(.N(N), .NREQ(NREQ), .TAGW(TAGW)) bus ();

  sqrt_scheduler #(.N(N), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  square_root #(.N(N)) eng (
    .clk_i  (Clock),
    .rst_i  (bus.sq_rst),
    .num_i  (bus.sq_num),
    .done_o (eng_done),
    .root_o (eng_root)
  );

  assign bus.sq_done = eng_done & ~force_low;
  assign bus.sq_root = eng_root;

  always #5 Clock = ~Clock;

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++) if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  // Samples the handshakes that the coming edge will complete, then advances one cycle.
  task automatic tick(output logic [NREQ-1:0] acc, output logic ohs, output logic [RW-1:0] oroot,
                      output logic [TAGW-1:0] otag);
    #1;
    acc   = bus.req_valid & bus.req_ready;
    ohs   = bus.out_valid & bus.out_ready;
    oroot = bus.out_root;
    otag  = bus.out_tag;
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int k, input logic v, input int d);
    bus.req_valid[k]        = v;
    bus.req_data[k*N +: N]  = N'(d);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge Clock);
    #3;
    reset = 1'b1;
    model_ptr = 0;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    @(posedge Clock);
    #1;
    checks++;
    if (bus.req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready);
    end
    checks++;
    if ({bus.sq_rst, bus.out_valid, bus.busy, bus.err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got sq_rst/out_valid/busy/err=%b expected 1000",
               {bus.sq_rst, bus.out_valid, bus.busy, bus.err});
    end
    checks++;
    if (bus.sq_num !== '0 || bus.out_root !== '0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL reset_data: got sq_num=%0d out_root=%0d out_tag=%0d expected 0 0 0",
               bus.sq_num, bus.out_root, bus.out_tag);
    end
    bus.req_valid = '0;
    #3;
    reset = 1'b1;
    model_ptr = 0;
    @(posedge Clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.sq_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b sq_rst=%b expected 0 1", bus.busy, bus.sq_rst);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    int k = 0;
    int grants = 0;
    set_req(0, 1'b1, 625);
    tick(acc, ohs, oroot, otag);
    checks++;
    if (acc !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b expected 0001", acc);
    end
    set_req(0, 1'b0, 625);
    model_ptr = 1;
    checks++;
    if (bus.sq_num !== 10'd625 || bus.sq_rst !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load: got sq_num=%0d sq_rst=%b busy=%b expected 625 0 1",
               bus.sq_num, bus.sq_rst, bus.busy);
    end
    while (bus.out_valid !== 1'b1 && k < 20) begin
      tick(acc, ohs, oroot, otag);
      if (acc !== '0) grants++;
      k++;
    end
    checks++;
    if (k !== int'(LAT)) begin
      errors++; $display("FAIL single_latency: got %0d edges expected %0d", k, LAT);
    end
    checks++;
    if (bus.out_root !== 5'd25 || bus.out_tag !== 2'd0 || grants !== 0) begin
      errors++;
      $display("FAIL single_result: got root=%0d tag=%0d extra_grants=%0d expected 25 0 0",
               bus.out_root, bus.out_tag, grants);
    end
    bus.out_ready = 1'b1;
    tick(acc, ohs, oroot, otag);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got out_valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_all_valid();
    logic [NREQ-1:0] acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    int data[NREQ] = '{0, 1, 1023, 100};
    int order[5] = '{0, 1, 2, 3, 0};
    int n_acc = 0;
    int n_res = 0;
    int last_acc = 0;
    int g;
    int t;
    apply_reset();
    exp_tag_q.delete(); exp_root_q.delete(); acc_cyc_q.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, data[i]);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && n_res < 5; c++) begin
      tick(acc, ohs, oroot, otag);
      if (acc !== '0 && n_acc < 5) begin
        g = onehot_idx(acc);
        checks++;
        if (g !== order[n_acc] || g !== rr_pick(bus.req_valid, model_ptr)) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", n_acc, g, order[n_acc]);
        end
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_acc !== int'(PERIOD)) begin
            errors++; $display("FAIL throughput: got %0d cycles expected %0d", cyc - last_acc, PERIOD);
          end
        end
        last_acc = cyc;
        model_ptr = (g + 1) % NREQ;
        exp_tag_q.push_back(g);
        exp_root_q.push_back(isqrt(data[g]));
        acc_cyc_q.push_back(cyc);
        n_acc++;
      end
      if (ohs === 1'b1 && exp_tag_q.size() > 0) begin
        t = acc_cyc_q.pop_front();
        checks++;
        if (int'(otag) !== exp_tag_q[0] || int'(oroot) !== exp_root_q[0] || cyc - t !== int'(LAT) + 1) begin
          errors++;
          $display("FAIL all_valid_result[%0d]: got tag=%0d root=%0d lat=%0d expected %0d %0d %0d",
                   n_res, otag, oroot, cyc - t, exp_tag_q[0], exp_root_q[0], LAT + 1);
        end
        void'(exp_tag_q.pop_front());
        void'(exp_root_q.pop_front());
        n_res++;
      end
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    checks++;
    if (n_res !== 5) begin
      errors++; $display("FAIL all_valid_count: got %0d results expected 5", n_res);
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    int d1 = int'($urandom_range(0, 1023));
    int d3 = int'($urandom_range(0, 1023));
    int k = 0;
    apply_reset();
    set_req(1, 1'b1, d1);
    set_req(3, 1'b1, d3);
    tick(acc, ohs, oroot, otag);
    checks++;
    if (acc !== 4'b0010) begin
      errors++; $display("FAIL bp_first_grant: got %b expected 0010", acc);
    end
    set_req(1, 1'b0, d1);
    model_ptr = 2;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      tick(acc, ohs, oroot, otag);
      k++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_root) !== isqrt(d1) || bus.out_tag !== 2'd1) begin
      errors++;
      $display("FAIL bp_result: got valid=%b root=%0d tag=%0d expected 1 %0d 1",
               bus.out_valid, bus.out_root, bus.out_tag, isqrt(d1));
    end
    for (int c = 0; c < 20; c++) begin
      tick(acc, ohs, oroot, otag);
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_root) !== isqrt(d1) || bus.out_tag !== 2'd1 ||
          bus.req_ready !== '0 || acc !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b root=%0d tag=%0d ready=%b expected 1 %0d 1 0000",
                 c, bus.out_valid, bus.out_root, bus.out_tag, bus.req_ready, isqrt(d1));
      end
    end
    bus.out_ready = 1'b1;
    tick(acc, ohs, oroot, otag);
    bus.out_ready = 1'b0;
    checks++;
    if (ohs !== 1'b1 || acc !== '0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ohs=%b acc=%b out_valid=%b expected 1 0000 0", ohs, acc, bus.out_valid);
    end
    tick(acc, ohs, oroot, otag);
    checks++;
    if (acc !== 4'b1000) begin
      errors++; $display("FAIL bp_next_grant: got %b expected 1000", acc);
    end
    set_req(3, 1'b0, d3);
    model_ptr = 0;
    bus.out_ready = 1'b1;
    k = 0;
    ohs = 1'b0;
    while (ohs !== 1'b1 && k < 20) begin
      tick(acc, ohs, oroot, otag);
      k++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (ohs !== 1'b1 || int'(oroot) !== isqrt(d3) || otag !== 2'd3) begin
      errors++;
      $display("FAIL bp_second_result: got ohs=%b root=%0d tag=%0d expected 1 %0d 3", ohs, oroot, otag, isqrt(d3));
    end
  endtask

  task automatic test_reset_midrun();
    logic [NREQ-1:0] acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    int k = 0;
    apply_reset();
    set_req(0, 1'b1, int'($urandom_range(0, 1023)));
    tick(acc, ohs, oroot, otag);
    set_req(0, 1'b0, 0);
    set_req(2, 1'b1, 144);
    tick(acc, ohs, oroot, otag);
    tick(acc, ohs, oroot, otag);
    checks++;
    if (bus.busy !== 1'b1 || bus.sq_rst !== 1'b0) begin
      errors++; $display("FAIL midrun_running: got busy=%b sq_rst=%b expected 1 0", bus.busy, bus.sq_rst);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.sq_rst !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.req_ready !== '0 ||
        bus.sq_num !== '0 || bus.out_tag !== '0 || bus.out_root !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got sq_rst=%b busy=%b out_valid=%b ready=%b sq_num=%0d expected 1 0 0 0000 0",
               bus.sq_rst, bus.busy, bus.out_valid, bus.req_ready, bus.sq_num);
    end
    #1;
    reset = 1'b1;
    model_ptr = 0;
    bus.out_ready = 1'b1;
    tick(acc, ohs, oroot, otag);
    checks++;
    if (acc !== 4'b0100) begin
      errors++; $display("FAIL midrun_regrant: got %b expected 0100", acc);
    end
    set_req(2, 1'b0, 144);
    model_ptr = 3;
    ohs = 1'b0;
    while (ohs !== 1'b1 && k < 20) begin
      tick(acc, ohs, oroot, otag);
      k++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (ohs !== 1'b1 || oroot !== 5'd12 || otag !== 2'd2) begin
      errors++; $display("FAIL midrun_result: got ohs=%b root=%0d tag=%0d expected 1 12 2", ohs, oroot, otag);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acc, mask, exp_acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    int data[NREQ];
    int n_res = 0;
    int g;
    bit model_idle = 1'b1;
    apply_reset();
    exp_tag_q.delete(); exp_root_q.delete();
    for (int c = 0; c < 3000 && n_res < 25; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          data[i] = int'($urandom_range(0, 1023));
          set_req(i, 1'b1, data[i]);
        end
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      mask = bus.req_valid;
      g = rr_pick(mask, model_ptr);
      exp_acc = (model_idle && g >= 0) ? NREQ'(1) << g : '0;
      tick(acc, ohs, oroot, otag);
      checks++;
      if (acc !== exp_acc) begin
        errors++; $display("FAIL rand_grant[c%0d]: got %b expected %b", cyc, acc, exp_acc);
      end
      if (acc !== '0) begin
        g = onehot_idx(acc);
        if (g >= 0) begin
          exp_tag_q.push_back(g);
          exp_root_q.push_back(isqrt(data[g]));
          model_ptr = (g + 1) % NREQ;
          set_req(g, 1'b0, data[g]);
        end
        model_idle = 1'b0;
      end
      if (ohs === 1'b1) begin
        checks++;
        if (exp_tag_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got tag=%0d root=%0d expected none", otag, oroot);
        end else begin
          if (int'(otag) !== exp_tag_q[0] || int'(oroot) !== exp_root_q[0]) begin
            errors++;
            $display("FAIL rand_result[%0d]: got tag=%0d root=%0d expected %0d %0d",
                     n_res, otag, oroot, exp_tag_q[0], exp_root_q[0]);
          end
          void'(exp_tag_q.pop_front());
          void'(exp_root_q.pop_front());
        end
        n_res++;
        model_idle = 1'b1;
      end
    end
    checks++;
    if (n_res < 25) begin
      errors++; $display("FAIL rand_progress: got %0d results expected 25", n_res);
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] acc;
    logic ohs;
    logic [RW-1:0] oroot;
    logic [TAGW-1:0] otag;
    apply_reset();
    force_low = 1'b1;
    set_req(1, 1'b1, int'($urandom_range(1, 1023)));
    tick(acc, ohs, oroot, otag);
    set_req(1, 1'b0, 0);
`ifdef SQRT_SCHED_TIMEOUT_EN
    begin
      int k = 0;
      while (bus.out_valid !== 1'b1 && k < 20) begin
        tick(acc, ohs, oroot, otag);
        k++;
      end
      checks++;
      if (k !== int'(PERIOD)) begin
        errors++; $display("FAIL timeout_edge: got %0d expected %0d", k, PERIOD);
      end
      checks++;
      if (bus.err !== 1'b1 || bus.out_root !== '0 || bus.out_tag !== 2'd1 || bus.sq_rst !== 1'b1) begin
        errors++;
        $display("FAIL timeout_result: got err=%b root=%0d tag=%0d sq_rst=%b expected 1 0 1 1",
                 bus.err, bus.out_root, bus.out_tag, bus.sq_rst);
      end
      bus.out_ready = 1'b1;
      tick(acc, ohs, oroot, otag);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
        errors++; $display("FAIL timeout_sticky: got busy=%b err=%b expected 0 1", bus.busy, bus.err);
      end
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick(acc, ohs, oroot, otag);
      checks++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout[%0d]: got busy=%b err=%b out_valid=%b expected 1 0 0",
                 c, bus.busy, bus.err, bus.out_valid);
      end
    end
`endif
    force_low = 1'b0;
    apply_reset();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
